// File: rtl/shift_tx_piso_pkg.sv
// rtl/shift_tx_piso_pkg.sv - state encodings, default width and clog2 helper shared by the shift link
package shift_tx_piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int SHIFT_DEFAULT_WIDTH = 8;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// rtl/shift_bit_counter.sv - bit-position up-counter with clear, enable and terminal flag
module shift_bit_counter
  import shift_tx_piso_pkg::*;
#(
  parameter int WIDTH = SHIFT_DEFAULT_WIDTH,
  localparam int CW   = clog2(WIDTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/shift_tx_piso.sv
// rtl/shift_tx_piso.sv - parallel-in/serial-out link transmitter, MSB or LSB first
// Define SHIFT_TX_PIPO_CHAIN_EN to accept the next word during the last bit (gapless frames).
module shift_tx_piso
  import shift_tx_piso_pkg::*;
#(
  parameter int WIDTH     = SHIFT_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] shifted;
  logic             done_q;
  logic             done_d;
  logic             last;
  logic             accept;
  logic             cnt_en;

  shift_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (cnt_en),
    .last  (last)
  );

`ifdef SHIFT_TX_PIPO_CHAIN_EN
  assign load_ready = (state_q == ST_IDLE) || last;
`else
  assign load_ready = (state_q == ST_IDLE);
`endif

  assign accept  = load_valid && load_ready;
  // Counter holds at WIDTH-1 after the last bit so it never wraps inside a frame.
  assign cnt_en  = (state_q == ST_SHIFT) && !last;
  assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d = load_data;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d = shifted;
        if (last) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          if (accept) begin
            shreg_d = load_data;
            state_d = ST_SHIFT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
    end
  end

  // All outputs decode flops only, so ser_out is settled long before the receiver's falling-edge sample.
  assign ser_out   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign ser_valid = (state_q == ST_SHIFT);
  assign busy      = (state_q == ST_SHIFT);
  assign done      = done_q;

endmodule

// File: tb/tb_shift_tx_piso.sv
// tb/tb_shift_tx_piso.sv - self-checking bench for shift_tx_piso (MSB-first and LSB-first instances)
module tb_shift_tx_piso;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] load_data = 8'h00;
  logic       load_valid = 1'b0;

  logic ready_m, sout_m, sval_m, busy_m, done_m;
  logic ready_l, sout_l, sval_l, busy_l, done_l;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  shift_tx_piso #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(ready_m), .ser_out(sout_m), .ser_valid(sval_m), .busy(busy_m), .done(done_m)
  );

  shift_tx_piso #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(ready_l), .ser_out(sout_l), .ser_valid(sval_l), .busy(busy_l), .done(done_l)
  );

`ifdef SHIFT_TX_PIPO_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Falling-edge SIPO receivers as used on the far end of the link
  logic [7:0] rx_m = 8'h00;
  logic [7:0] rx_l = 8'h00;
  always @(negedge clk) begin
    if (sval_m) rx_m <= {rx_m[6:0], sout_m};
    if (sval_l) rx_l <= {rx_l[6:0], sout_l};
  end

  // Reference model: a queue of bits still to be sent per instance
  bit   qm[$];
  bit   ql[$];
  logic done_x = 1'b0;

  function automatic bit model_ready();
    return (qm.size() == 0) || (CHAIN && qm.size() == 1);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      qm.delete();
      ql.delete();
      done_x = 1'b0;
    end else begin
      bit acc;
      acc    = load_valid && model_ready();
      done_x = (qm.size() == 1);
      if (qm.size() > 0) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (acc) begin
        for (int i = 0; i < 8; i++) begin
          qm.push_back(load_data[7-i]);
          ql.push_back(load_data[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_ser_valid_m", sval_m, qm.size() > 0);
      chk("model_ser_valid_l", sval_l, ql.size() > 0);
      chk("model_busy_m", busy_m, qm.size() > 0);
      chk("model_ser_out_m", sout_m, (qm.size() > 0) ? qm[0] : 1'b0);
      chk("model_ser_out_l", sout_l, (ql.size() > 0) ? ql[0] : 1'b0);
      chk("model_load_ready_m", ready_m, model_ready());
      chk("model_done_m", done_m, done_x);
      chk("model_done_l", done_l, done_x);
    end
  end

  // Event counters for multi-cycle sequences (snapshots taken by the test)
  int tot_done = 0;
  int tot_rise = 0;
  logic sval_prev = 1'b0;
  always @(negedge clk) begin
    if (done_m) tot_done++;
    if (sval_m && !sval_prev) tot_rise++;
    sval_prev <= sval_m;
  end

  task automatic send(input logic [7:0] w, input bit keep);
    bit ok;
    ok = 1'b0;
    load_data  = w;
    load_valid = 1'b1;
    for (int t = 0; t < 40 && !ok; t++) begin
      ok = ready_m;
      @(negedge clk);
    end
    chk("accept_within_bound", ok, 1'b1);
    if (!keep) load_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    send(v.word, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("vec_valid_m", sval_m, 1'b1);
      chk("vec_bit_m", sout_m, v.exp_m[7-i]);
      chk("vec_bit_l", sout_l, v.exp_l[7-i]);
      @(negedge clk);
    end
    chk("vec_done_m", done_m, 1'b1);
    chk("vec_done_l", done_l, 1'b1);
    chk("vec_gap_valid", sval_m, 1'b0);
    chk("vec_rx_m", rx_m, v.exp_m);
    chk("vec_rx_l", rx_l, v.exp_l);
    @(negedge clk);
    chk("vec_done_one_cycle", done_m, 1'b0);
  endtask

  initial begin
    int d0, r0;

    vecs[0] = '{word: 8'hA5, exp_m: 8'hA5, exp_l: 8'hA5};
    vecs[1] = '{word: 8'h01, exp_m: 8'h01, exp_l: 8'h80};
    vecs[2] = '{word: 8'h80, exp_m: 8'h80, exp_l: 8'h01};
    vecs[3] = '{word: 8'h3C, exp_m: 8'h3C, exp_l: 8'h3C};
    vecs[4] = '{word: 8'hC3, exp_m: 8'hC3, exp_l: 8'hC3};
    vecs[5] = '{word: 8'h0F, exp_m: 8'h0F, exp_l: 8'hF0};

    // Reset state with the clock running
    repeat (3) @(negedge clk);
    chk("rst_ser_out", sout_m, 1'b0);
    chk("rst_ser_valid", sval_m, 1'b0);
    chk("rst_busy", busy_m, 1'b0);
    chk("rst_done", done_m, 1'b0);
    chk("rst_load_ready_m", ready_m, 1'b1);
    chk("rst_load_ready_l", ready_l, 1'b1);
    reset  = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Two words back to back with load_valid held high
    d0 = tot_done;
    r0 = tot_rise;
    send(8'h3C, 1'b1);
    send(8'hC3, 1'b0);
    repeat (20) @(negedge clk);
    chk("b2b_done_pulses", tot_done - d0, 2);
    chk("b2b_valid_bursts", tot_rise - r0, CHAIN ? 1 : 2);
    chk("b2b_rx", rx_m, 8'hC3);

    // Reset in the middle of a frame
    send(8'hFF, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort_pre_valid", sval_m, 1'b1);
    d0 = tot_done;
    #2;
    chk_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("abort_valid_async", sval_m, 1'b0);
    chk("abort_busy_async", busy_m, 1'b0);
    chk("abort_ready_async", ready_m, 1'b1);
    chk("abort_ser_out_async", sout_m, 1'b0);
    @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_done", tot_done - d0, 0);
    run_vec(vecs[5]);

    // Input activity while busy must not disturb the frame
    d0 = tot_done;
    send(8'hA5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      load_data  = 8'($urandom);
      load_valid = i[0];
      chk("busy_toggle_bit", sout_m, vecs[0].exp_m[7-i]);
      @(negedge clk);
    end
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_toggle_done", done_m, 1'b1);
    chk("busy_toggle_rx", rx_m, 8'hA5);
    repeat (4) @(negedge clk);
    chk("busy_toggle_no_extra", busy_m, 1'b0);
    chk("busy_toggle_one_done", tot_done - d0, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(8'($urandom), 1'($urandom_range(0, 1)));
    end
    load_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("random_idle_end", busy_m, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
